bcd_share_sched: RTL and testbench
==================================

// Module: bcd_share_sched
// PURPOSE
//  Iterative (one shift per clock) binary-to-BCD conversion engine shared by
//  two requesters under round-robin arbitration. Replaces per-source
//  combinational converters feeding the 6-digit 7-seg display path with one
//  multi-cycle datapath. Operands are captured on grant; results are held in
//  an output register until the next conversion completes.
// PARAMETERS
//  WIDTH   20  binary operand width; also the number of shift cycles
//  DIGITS  6   number of BCD digits; saturation value MAXV = 10**DIGITS-1
// PORTS
//  clk       in   1         system clock; all logic on rising edge
//  reset     in   1         synchronous, active-low reset (0 = reset)
//  req0      in   1         requester 0 wants a conversion
//  bin0      in   WIDTH     requester 0 operand; held stable while req0=1
//  req1      in   1         requester 1 wants a conversion
//  bin1      in   WIDTH     requester 1 operand; held stable while req1=1
//  grant0    out  1         1-cycle pulse: bin0 captured
//  grant1    out  1         1-cycle pulse: bin1 captured
//  busy      out  1         1 whenever state != IDLE
//  done      out  1         1-cycle pulse: bcd_out/done_id/ovf updated
//  done_id   out  1         requester index of the result in bcd_out
//  ovf       out  1         operand exceeded MAXV; result saturated
//  bcd_out   out  4*DIGITS  digit k at [4k+3:4k]; digit 0 = least significant
// BEHAVIOUR
//  Reset (reset=0 at a clock edge): state=IDLE; grant0/1, done, busy, ovf,
//   done_id, bcd_out all 0; rr_last=1 (req0 wins the first tie). Reset at any
//   point aborts the conversion in flight; no done pulse is issued for it.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: req sampled only here. If any req is high, pick the winner:
//   only one high -> that one; both high -> the one != rr_last.
//   At the edge: capture winner's operand into shift reg, clear all digit
//   accumulators, cnt=WIDTH, ovf_pend=(operand > MAXV), id_pend=winner,
//   rr_last=winner, grantX=1 for the next cycle, state=SHIFT.
//  SHIFT: one double-dabble step per cycle: every digit >=5 gets +3
//   (4-bit, no carry out), then {digits,shift reg} shifts left by 1 with the
//   operand MSB entering digit0[0]. cnt decrements; on the step where cnt=1,
//   state=DONE and bcd_out <= ovf_pend ? all digits 9 : digits;
//   ovf<=ovf_pend; done_id<=id_pend.
//  DONE: done=1 for this single cycle; next edge -> IDLE.
//  Timing: capture edge = E0; grant high in cycle E0..E1; done high in cycle
//   after edge E(WIDTH); earliest next capture at E(WIDTH+2). Sustained
//   period is WIDTH+2 cycles (22 by default).
//  Requester contract: drop req in the cycle grantX is seen. If req is still
//   high when the FSM returns to IDLE, it is treated as a new request.
//  Outputs bcd_out/ovf/done_id hold their value between done pulses.
//  If WIDTH bits cannot exceed MAXV, ovf is constant 0.
// TESTING
//  1. req0, bin0=123456 -> grant0 at E1; done 20 cycles later;
//     bcd_out=24'h123456, done_id=0, ovf=0.
//  2. bin0=0 -> 24'h000000; bin0=999999 -> 24'h999999, ovf=0;
//     bin0=10 -> 24'h000010.
//  3. bin1=20'hFFFFF (1048575) -> bcd_out=24'h999999, ovf=1, done_id=1.
//  4. req0 (bin0=111111) and req1 (bin1=222222) held high from reset release
//     -> grants alternate 0,1,0,1 with 22-cycle spacing; results alternate.
//  5. reset=0 during SHIFT step 10 -> next cycle busy=0, bcd_out=0, no done;
//     a following req0 with bin0=54321 returns 24'h054321.
//  6. Only req1 active, repeated 3 times -> each request is served by grant1;
//     rr_last does not block a lone requester.

Source files
------------

// File: rtl/bcd_share_sched.sv
// Shared iterative binary-to-BCD converter (double dabble, one shift per clock)
// serving two requesters under round-robin arbitration.
module bcd_share_sched #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [WIDTH-1:0]      bin0,
  input  logic                  req1,
  input  logic [WIDTH-1:0]      bin1,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BW  = 4 * DIGITS;
  localparam int TOT = BW + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAXV = pow10_minus1(DIGITS);
  localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_shift;
  logic [BW-1:0]     r_digits;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf_pend;
  logic              r_id_pend;
  logic              r_rr_last;
  logic              r_grant0;
  logic              r_grant1;
  logic              r_done;
  logic              r_done_id;
  logic              r_ovf;
  logic [BW-1:0]     r_bcd;

  logic              w_any;
  logic              w_win;
  logic [WIDTH-1:0]  w_win_bin;
  logic [63:0]       w_op_ext;
  logic [BW-1:0]     w_adj;
  logic [TOT-1:0]    w_step;

  // Tie goes to the requester that did not win last time.
  assign w_any     = req0 | req1;
  assign w_win     = (req0 && req1) ? ~r_rr_last : req1;
  assign w_win_bin = w_win ? bin1 : bin0;
  assign w_op_ext  = 64'(w_win_bin);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_adj = r_digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_digits[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_digits[4*k +: 4] + 4'd3;
    end
    // Top bit of the concatenation falls off; it is always 0 for a valid operand width.
    w_step = {w_adj, r_shift} << 1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_digits   <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_id_pend  <= 1'b0;
      r_rr_last  <= 1'b1;
      r_grant0   <= 1'b0;
      r_grant1   <= 1'b0;
      r_done     <= 1'b0;
      r_done_id  <= 1'b0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
    end else begin
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_shift    <= w_win_bin;
            r_digits   <= '0;
            r_cnt      <= CW'(WIDTH);
            r_ovf_pend <= (w_op_ext > MAXV);
            r_id_pend  <= w_win;
            r_rr_last  <= w_win;
            r_grant0   <= ~w_win;
            r_grant1   <= w_win;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_digits <= w_step[TOT-1:WIDTH];
          r_shift  <= w_step[WIDTH-1:0];
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state   <= S_DONE;
            r_bcd     <= r_ovf_pend ? ALL_NINES : w_step[TOT-1:WIDTH];
            r_ovf     <= r_ovf_pend;
            r_done_id <= r_id_pend;
            r_done    <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant0  = r_grant0;
  assign grant1  = r_grant1;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign done_id = r_done_id;
  assign ovf     = r_ovf;
  assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bcd_share_sched.sv
// Directed self-checking bench for bcd_share_sched: single conversions,
// saturation, round-robin alternation, mid-conversion reset.
module tb_bcd_share_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [19:0] bin0, bin1;
  logic        grant0, grant1, busy, done, done_id, ovf;
  logic [23:0] bcd_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bcd_share_sched #(.WIDTH(20), .DIGITS(6)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
    .grant0(grant0), .grant1(grant1), .busy(busy), .done(done),
    .done_id(done_id), .ovf(ovf), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait up to 'limit' negedges for a grant; returns the count taken.
  task automatic wait_grant(input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!(grant0 || grant1) && n < limit);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < limit);
  endtask

  task automatic run_conv(input string tag, input logic src, input logic [19:0] val,
                          input logic [23:0] exp_bcd, input logic exp_ovf);
    int n;
    @(negedge clk);
    if (src) begin req1 = 1'b1; bin1 = val; end
    else     begin req0 = 1'b1; bin0 = val; end
    wait_grant(8, n);
    check({tag, "_grant_lat"}, n, 1);
    check({tag, "_grant_id"}, {grant1, grant0}, src ? 2'b10 : 2'b01);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done(40, n);
    check({tag, "_done_lat"}, n, 20);
    check({tag, "_bcd"}, bcd_out, exp_bcd);
    check({tag, "_ovf"}, ovf, exp_ovf);
    check({tag, "_id"}, done_id, src);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    int last_cyc;
    int ndone;
    logic [23:0] held;

    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
    repeat (3) @(negedge clk);
    check("rst_grant0", grant0, 1'b0);
    check("rst_grant1", grant1, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_done_id", done_id, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_bcd", bcd_out, 24'h0);
    reset = 1'b1;

    // Single conversions, including digit and saturation boundaries.
    run_conv("c123456", 1'b0, 20'd123456, 24'h123456, 1'b0);
    run_conv("c0",      1'b0, 20'd0,      24'h000000, 1'b0);
    run_conv("c999999", 1'b0, 20'd999999, 24'h999999, 1'b0);
    run_conv("c10",     1'b0, 20'd10,     24'h000010, 1'b0);
    run_conv("cmax",    1'b1, 20'hFFFFF,  24'h999999, 1'b1);
    run_conv("c1e6",    1'b1, 20'd1000000, 24'h999999, 1'b1);
    run_conv("c987",    1'b1, 20'd987,    24'h000987, 1'b0);

    // Outputs hold between done pulses.
    held = bcd_out;
    repeat (5) @(negedge clk);
    check("hold_bcd", bcd_out, held);
    check("hold_ovf", ovf, 1'b0);

    // Both requesters held high from reset release: 0,1,0,1 at 22-cycle spacing.
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; bin0 = 20'd111111;
    req1 = 1'b1; bin1 = 20'd222222;
    @(negedge clk);
    reset = 1'b1;
    last_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      wait_grant(30, n);
      check($sformatf("rr%0d_grant_id", g), {grant1, grant0}, (g % 2) ? 2'b10 : 2'b01);
      if (g > 0) check($sformatf("rr%0d_spacing", g), cyc - last_cyc, 22);
      last_cyc = cyc;
      wait_done(40, n);
      check($sformatf("rr%0d_bcd", g), bcd_out, (g % 2) ? 24'h222222 : 24'h111111);
      check($sformatf("rr%0d_id", g), done_id, g % 2);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_idle", busy, 1'b0);

    // Reset on shift step 10 aborts silently.
    req0 = 1'b1; bin0 = 20'd777777;
    wait_grant(8, n);
    check("abort_grant", grant0, 1'b1);
    req0 = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_bcd", bcd_out, 24'h0);
    check("abort_done", done, 1'b0);
    reset = 1'b1;
    ndone = 0;
    repeat (25) begin @(negedge clk); if (done) ndone++; end
    check("abort_no_done", ndone, 0);
    run_conv("c54321", 1'b0, 20'd54321, 24'h054321, 1'b0);

    // Lone requester 1 is never blocked by rr_last.
    run_conv("r1a", 1'b1, 20'd5,      24'h000005, 1'b0);
    run_conv("r1b", 1'b1, 20'd99,     24'h000099, 1'b0);
    run_conv("r1c", 1'b1, 20'd500000, 24'h500000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
